// File: rtl/usensor_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : usensor_responder                                          |
// | Description : HC-SR04 ultrasonic sensor emulator. Watches trig and       |
// |               returns an echo pulse whose width encodes distance_cm.     |
// |               Optional macro USENSOR_RESPONDER_JITTER_EN adds 0..15      |
// |               cycles of LFSR noise to each echo width.                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module usensor_responder #(
    parameter int unsigned CYCLES_PER_CM   = 2900,
    parameter int unsigned MIN_TRIG_CYCLES = 500,
    parameter int unsigned BURST_CYCLES    = 10000,
    parameter int unsigned MAX_CM          = 400,
    parameter int unsigned NO_ECHO_CYCLES  = 1900000,
    parameter int unsigned HOLDOFF_CYCLES  = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       trig,
    input  logic [8:0] distance_cm,
    input  logic       object_present,
    output logic       echo,
    output logic       busy,
    output logic       pulse_done,
    output logic       trig_short
);

    // State encoding
    localparam logic [2:0] c_s_idle    = 3'd0;
    localparam logic [2:0] c_s_trig    = 3'd1;
    localparam logic [2:0] c_s_delay   = 3'd2;
    localparam logic [2:0] c_s_echo    = 3'd3;
    localparam logic [2:0] c_s_holdoff = 3'd4;

    // All counting is done at 22 bits, wide enough for the no-echo width
    localparam logic [21:0] c_min_trig      = 22'(MIN_TRIG_CYCLES);
    localparam logic [21:0] c_cycles_per_cm = 22'(CYCLES_PER_CM);
    localparam logic [21:0] c_max_cm        = 22'(MAX_CM);
    localparam logic [21:0] c_no_echo       = 22'(NO_ECHO_CYCLES);
    // Last-cycle compare values; unused when the matching state is skipped
    localparam logic [21:0] c_burst_last    = 22'((BURST_CYCLES   == 0) ? 0 : BURST_CYCLES   - 1);
    localparam logic [21:0] c_holdoff_last  = 22'((HOLDOFF_CYCLES == 0) ? 0 : HOLDOFF_CYCLES - 1);
    localparam logic [2:0]  c_after_trig    = (BURST_CYCLES   == 0) ? c_s_echo : c_s_delay;
    localparam logic [2:0]  c_after_echo    = (HOLDOFF_CYCLES == 0) ? c_s_idle : c_s_holdoff;

    logic [2:0]  r_state;
    logic [2:0]  w_next;
    logic        r_trig_meta;
    logic        r_trig_s;
    logic        r_trig_prev;
    logic [21:0] r_cnt;
    logic [21:0] r_width;
    logic        r_pulse_done;
    logic        w_trig_rise;
    logic        w_accept;
    logic [8:0]  w_dist_eff;
    logic [21:0] w_base_width;
    logic [21:0] w_width;

    assign w_trig_rise = r_trig_s & ~r_trig_prev;
    assign w_accept    = (r_state == c_s_trig) && !r_trig_s && (r_cnt >= c_min_trig);

    // Echo width: a 0 cm target is reported as 1 cm; out of range gives no echo
    assign w_dist_eff   = (distance_cm == 9'd0) ? 9'd1 : distance_cm;
    assign w_base_width = (!object_present || (22'(distance_cm) > c_max_cm))
                          ? c_no_echo
                          : 22'(w_dist_eff) * c_cycles_per_cm;

`ifdef USENSOR_RESPONDER_JITTER_EN
    logic [15:0] r_lfsr;

    // Noise source: 16-bit Fibonacci LFSR, stepped once per accepted trig
    always_ff @(posedge clock) begin
        if (reset) begin
            r_lfsr <= 16'hACE1;
        end else if (w_accept) begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        end
    end

    assign w_width = w_base_width + {18'd0, r_lfsr[3:0]};
`else
    assign w_width = w_base_width;
`endif

    // Two-flop synchronizer plus a delayed copy for rising-edge detection
    always_ff @(posedge clock) begin
        if (reset) begin
            r_trig_meta <= 1'b0;
            r_trig_s    <= 1'b0;
            r_trig_prev <= 1'b0;
        end else begin
            r_trig_meta <= trig;
            r_trig_s    <= r_trig_meta;
            r_trig_prev <= r_trig_s;
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_s_idle;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_s_idle: begin
                if (w_trig_rise) w_next = c_s_trig;
            end
            c_s_trig: begin
                if (!r_trig_s) w_next = w_accept ? c_after_trig : c_s_idle;
            end
            c_s_delay: begin
                if (r_cnt == c_burst_last) w_next = c_s_echo;
            end
            c_s_echo: begin
                if (r_cnt == r_width - 22'd1) w_next = c_after_echo;
            end
            c_s_holdoff: begin
                if (r_cnt == c_holdoff_last) w_next = c_s_idle;
            end
            default: w_next = c_s_idle;
        endcase
    end

    // Shared counter: trig width in TRIG, elapsed cycles in the timed states
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt <= 22'd0;
        end else if (r_state == c_s_idle) begin
            r_cnt <= w_trig_rise ? 22'd1 : 22'd0;
        end else if ((r_state == c_s_trig) && r_trig_s) begin
            r_cnt <= (r_cnt >= c_min_trig) ? r_cnt : r_cnt + 22'd1;
        end else if (w_next != r_state) begin
            r_cnt <= 22'd0;
        end else begin
            r_cnt <= r_cnt + 22'd1;
        end
    end

    // Latch the echo width at acceptance so later input changes are ignored
    always_ff @(posedge clock) begin
        if (reset) begin
            r_width <= 22'd0;
        end else if (w_accept) begin
            r_width <= w_width;
        end
    end

    // pulse_done strobes on the first cycle after the echo's last high cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pulse_done <= 1'b0;
        end else begin
            r_pulse_done <= (r_state == c_s_echo) && (w_next != c_s_echo);
        end
    end

    // Output decode
    always_comb begin
        echo       = (r_state == c_s_echo);
        busy       = (r_state != c_s_idle);
        pulse_done = r_pulse_done;
        trig_short = (r_state == c_s_trig) && !r_trig_s && (r_cnt < c_min_trig);
    end

endmodule
`default_nettype wire
